// File: rtl/dac_pkg.sv
// dac_pkg: shared definitions for the serial-DAC streamer.
//   dac_state_e  - FSM state encoding (IDLE/LOAD/SHIFT/GAP)
//   PD_*         - DAC power-down mode codes carried in each frame
//   dac_clog2    - ceiling log2 used to size counters and the channel field
package dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } dac_state_e;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  function automatic int dac_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dac_spi_streamer_sclk_gen.sv
// dac_sclk_gen: SCLK divider for the DAC streamer.
//   clk, rst       system clock, async active-high reset
//   i_en           run the divider (high only while shifting)
//   o_sclk         registered serial clock, idles high
//   o_rise_tick    strobe: o_sclk goes 0->1 at the next clk edge
//   o_fall_tick    strobe: o_sclk goes 1->0 at the next clk edge
// Each SCLK half-period lasts CLK_DIV clk cycles; a period starts high.
module dac_sclk_gen
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int DIV_W = (dac_clog2(CLK_DIV) > 1) ? dac_clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sclk;
  logic             w_phase_end;

  assign w_phase_end = i_en && (r_div_cnt == DIV_LAST);
  assign o_fall_tick = w_phase_end && r_sclk;
  assign o_rise_tick = w_phase_end && !r_sclk;
  assign o_sclk      = r_sclk;

  // Disabled: park high with the divider cleared so the first SHIFT cycle
  // starts a fresh high phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b1;
    end else if (!i_en) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b1;
    end else if (w_phase_end) begin
      r_div_cnt <= '0;
      r_sclk    <= ~r_sclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_spi_streamer.sv
// dac_spi_streamer: serial-DAC master. Takes one sample per valid/ready
// handshake and shifts the frame {chan, pd, data, zero pad} MSB first.
//   clk, rst                 system clock, async active-high reset
//   s_valid/s_ready          sample handshake (s_ready high only in IDLE)
//   s_data, s_chan, s_pd     sample, target channel, power-down mode
//   busy                     registered, high while a frame is in flight
//   done                     registered 1-cycle pulse as SYNC_N rises
//   dac_sclk/sync_n/din      registered DAC pins
//
// state | meaning
// IDLE  | waiting for a sample; s_ready high
// LOAD  | one cycle, SYNC_N low, MSB already on DIN
// SHIFT | FRAME_W SCLK periods, DIN advances on each rising edge
// GAP   | SYNC_N high for SYNC_GAP cycles before the next accept
module dac_spi_streamer
  import dac_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int FRAME_W  = 16,
  parameter  int CHANNELS = 1,
  parameter  int CLK_DIV  = 1,
  parameter  int SYNC_GAP = 1,
  localparam int CH_W     = (dac_clog2(CHANNELS) > 1) ? dac_clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [CH_W-1:0]   s_chan,
  input  logic [1:0]        s_pd,
  output logic              busy,
  output logic              done,
  output logic              dac_sclk,
  output logic              dac_sync_n,
  output logic              dac_din
);

  localparam int PAD_W = FRAME_W - CH_W - 2 - DATA_W;
  localparam int BIT_W = (dac_clog2(FRAME_W) > 1) ? dac_clog2(FRAME_W) : 1;
  localparam int GAP_W = (dac_clog2(SYNC_GAP) > 1) ? dac_clog2(SYNC_GAP) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SYNC_GAP - 1);

  if (PAD_W < 0 || CLK_DIV < 1 || SYNC_GAP < 1) begin : g_param_check
    $fatal(1, "dac_spi_streamer: FRAME_W too small for CH_W+2+DATA_W, or CLK_DIV/SYNC_GAP < 1");
  end

  dac_state_e         r_state;
  logic [FRAME_W-1:0] r_shreg;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_last_fell;
  logic               r_sync_n;
  logic               r_done;
  logic               r_busy;

  logic [FRAME_W-1:0] w_frame;
  logic               w_accept;
  logic               w_sclk;
  logic               w_rise_tick;
  logic               w_fall_tick;

  // Left-justify the fields; the pad bits fall out of the shift as zeros.
  assign w_frame  = FRAME_W'({s_chan, s_pd, s_data}) << PAD_W;
  assign s_ready  = (r_state == ST_IDLE) && !rst;
  assign w_accept = s_valid && s_ready;

  dac_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk         (clk),
    .rst         (rst),
    .i_en        (r_state == ST_SHIFT),
    .o_sclk      (w_sclk),
    .o_rise_tick (w_rise_tick),
    .o_fall_tick (w_fall_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_last_fell <= 1'b0;
      r_sync_n    <= 1'b1;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_LOAD;
            r_shreg     <= w_frame;
            r_bit_cnt   <= '0;
            r_last_fell <= 1'b0;
            r_sync_n    <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // Once the DAC has taken the last bit, the next rising edge closes
          // the frame instead of advancing DIN.
          if (w_fall_tick && (r_bit_cnt == BIT_LAST)) begin
            r_last_fell <= 1'b1;
          end
          if (w_rise_tick) begin
            if (r_last_fell) begin
              r_state   <= ST_GAP;
              r_sync_n  <= 1'b1;
              r_done    <= 1'b1;
              r_gap_cnt <= GAP_LOAD;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shreg   <= {r_shreg[FRAME_W-2:0], 1'b0};
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dac_sclk   = w_sclk;
  assign dac_sync_n = r_sync_n;
  assign dac_din    = r_shreg[FRAME_W-1];
  assign done       = r_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_dac_spi_streamer.sv
module tb_dac_spi_streamer;

  typedef struct {
    logic [15:0] word;
    int          falls;
    int          low;
    logic        done_at_rise;
  } rx_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  // main instance: DATA_W=8 FRAME_W=16 CHANNELS=4 CLK_DIV=2 SYNC_GAP=2
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic [1:0] s_chan = '0;
  logic [1:0] s_pd = '0;
  logic       busy, done, dac_sclk, dac_sync_n, dac_din;

  // second instance: CLK_DIV=1 SYNC_GAP=1 CHANNELS=1
  logic       v5 = 1'b0;
  logic       r5;
  logic [7:0] d5 = '0;
  logic [0:0] c5 = '0;
  logic [1:0] p5 = '0;
  logic       busy5, done5, sclk5, sync5, din5;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_spi_streamer #(.DATA_W(8), .FRAME_W(16), .CHANNELS(4), .CLK_DIV(2), .SYNC_GAP(2)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_chan(s_chan), .s_pd(s_pd), .busy(busy), .done(done), .dac_sclk(dac_sclk),
    .dac_sync_n(dac_sync_n), .dac_din(dac_din));

  dac_spi_streamer #(.DATA_W(8), .FRAME_W(16), .CHANNELS(1), .CLK_DIV(1), .SYNC_GAP(1)) dut5 (
    .clk(clk), .rst(rst), .s_valid(v5), .s_ready(r5), .s_data(d5),
    .s_chan(c5), .s_pd(p5), .busy(busy5), .done(done5), .dac_sclk(sclk5),
    .dac_sync_n(sync5), .dac_din(din5));

  // reference frame layouts: {chan, pd, data, zero pad}
  function automatic logic [15:0] exp_frame(input logic [7:0] d, input logic [1:0] c, input logic [1:0] p);
    return {c, p, d, 4'b0000};
  endfunction

  function automatic logic [15:0] exp_frame5(input logic [7:0] d, input logic [0:0] c, input logic [1:0] p);
    return {c, p, d, 5'b00000};
  endfunction

  logic [15:0] exp_q[$];
  logic [15:0] exp5_q[$];
  rx_t         rx_q[$];
  logic [15:0] rx5_q[$];
  int          acc_q[$];
  int          acc5_q[$];
  int          done_q[$];
  int          gap_q[$];
  int          done_cnt = 0;
  int          ready_err = 0;

  // main monitor: assembles the DIN bits seen at each SCLK fall inside a SYNC_N low window
  logic [15:0] m_word;
  int          m_falls = 0, m_low = 0, m_high = 0;
  logic        m_active = 1'b0, m_prev_sclk = 1'b1, m_prev_sync = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_prev_sclk = 1'b1; m_prev_sync = 1'b1; m_falls = 0; m_high = 0;
    end else begin
      if (s_valid && s_ready) acc_q.push_back(cyc + 1);
      if (done) begin done_cnt++; done_q.push_back(cyc); end
      if (busy && s_ready) ready_err++;
      if (m_prev_sync && !dac_sync_n) begin
        gap_q.push_back(m_high);
        m_active = 1'b1; m_word = '0; m_falls = 0; m_low = 0;
      end
      if (m_active && m_prev_sclk && !dac_sclk) begin
        m_word = {m_word[14:0], dac_din};
        m_falls++;
      end
      if (m_active && !m_prev_sync && dac_sync_n) begin
        rx_q.push_back('{m_word, m_falls, m_low, done});
        m_active = 1'b0; m_high = 0;
      end
      if (dac_sync_n) m_high++; else m_low++;
      m_prev_sclk = dac_sclk;
      m_prev_sync = dac_sync_n;
    end
  end

  logic [15:0] w5;
  logic        a5 = 1'b0, ps5 = 1'b1, py5 = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      a5 = 1'b0; ps5 = 1'b1; py5 = 1'b1;
    end else begin
      if (v5 && r5) acc5_q.push_back(cyc + 1);
      if (py5 && !sync5) begin a5 = 1'b1; w5 = '0; end
      if (a5 && ps5 && !sclk5) w5 = {w5[14:0], din5};
      if (a5 && !py5 && sync5) begin rx5_q.push_back(w5); a5 = 1'b0; end
      ps5 = sclk5;
      py5 = sync5;
    end
  end

  task automatic drive_sample(input logic [7:0] d, input logic [1:0] c, input logic [1:0] p);
    int n;
    n = 0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = d; s_chan = c; s_pd = p;
    exp_q.push_back(exp_frame(d, c, p));
    while (!s_ready && n < 1000) begin @(posedge clk); #1; n++; end
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL accept_timeout s_ready=%b want=1", s_ready); end
    @(posedge clk); #1;
    // scramble the fields after accept: the frame in flight must not change
    s_valid = 1'b0; s_data = ~d; s_chan = ~c; s_pd = ~p;
  endtask

  task automatic wait_frames(input int count);
    int n;
    n = 0;
    while (rx_q.size() < count && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (rx_q.size() < count) begin failures++; $display("FAIL frame_timeout got=%0d frames want=%0d", rx_q.size(), count); end
  endtask

  task automatic clear_all();
    exp_q.delete(); rx_q.delete(); acc_q.delete(); done_q.delete(); gap_q.delete();
    done_cnt = 0; ready_err = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (dac_sclk !== 1'b1)   begin failures++; $display("FAIL reset_sclk got=%b want=1", dac_sclk); end
    checks++; if (dac_sync_n !== 1'b1) begin failures++; $display("FAIL reset_sync_n got=%b want=1", dac_sync_n); end
    checks++; if (dac_din !== 1'b0)    begin failures++; $display("FAIL reset_din got=%b want=0", dac_din); end
    checks++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1)    begin failures++; $display("FAIL reset_ready got=%b want=1", s_ready); end
  endtask

  task automatic test_single();
    rx_t r;
    logic [15:0] e;
    clear_all();
    drive_sample(8'hA5, 2'd2, 2'b00);
    wait_frames(1);
    repeat (6) @(negedge clk);
    if (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r.word !== e)         begin failures++; $display("FAIL single_word got=%h want=%h", r.word, e); end
      checks++; if (r.falls !== 16)       begin failures++; $display("FAIL single_falls got=%0d want=16", r.falls); end
      checks++; if (r.low !== 65)         begin failures++; $display("FAIL single_sync_low got=%0d want=65", r.low); end
      checks++; if (r.done_at_rise !== 1'b1) begin failures++; $display("FAIL single_done_at_rise got=%b want=1", r.done_at_rise); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL single_done_count got=%0d want=1", done_cnt); end
    if (done_q.size() > 0 && acc_q.size() > 0) begin
      checks++;
      if (done_q[0] - acc_q[0] !== 65) begin failures++; $display("FAIL single_done_latency got=%0d want=65", done_q[0] - acc_q[0]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    rx_t r;
    logic [15:0] e;
    clear_all();
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 8'h01; s_chan = 2'd0; s_pd = 2'b00;
    exp_q.push_back(exp_frame(8'h01, 2'd0, 2'b00));
    n = 0; while (!s_ready && n < 1000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    s_data = 8'hFF;
    exp_q.push_back(exp_frame(8'hFF, 2'd0, 2'b00));
    n = 0; while (!s_ready && n < 1000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    s_valid = 1'b0;
    wait_frames(2);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rx_q.size() > 0 && exp_q.size() > 0) begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        checks++; if (r.word !== e) begin failures++; $display("FAIL b2b_word%0d got=%h want=%h", i, r.word, e); end
      end
    end
    checks++;
    if (gap_q.size() !== 2 || gap_q[1] !== 3) begin
      failures++; $display("FAIL b2b_sync_high got=%0d entries, last=%0d want=2 entries, last=3", gap_q.size(), gap_q[gap_q.size()-1]);
    end
    checks++;
    if (acc_q.size() !== 2 || acc_q[1] - acc_q[0] !== 68) begin
      failures++; $display("FAIL b2b_accept_spacing got=%0d accepts want=2 spaced 68", acc_q.size());
    end
    checks++; if (ready_err !== 0) begin failures++; $display("FAIL b2b_ready_while_busy got=%0d want=0", ready_err); end
  endtask

  task automatic test_ignore_busy();
    int n;
    rx_t r;
    logic [15:0] e;
    clear_all();
    drive_sample(8'h11, 2'd1, 2'b01);
    n = 0; while (m_falls < 3 && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 8'h99; s_chan = 2'd3; s_pd = 2'b10;
    @(posedge clk); #1;
    s_valid = 1'b0;
    wait_frames(1);
    repeat (10) @(negedge clk);
    checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL ignore_frame_count got=%0d want=1", rx_q.size()); end
    checks++; if (acc_q.size() !== 1) begin failures++; $display("FAIL ignore_accept_count got=%0d want=1", acc_q.size()); end
    if (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r.word !== e) begin failures++; $display("FAIL ignore_word got=%h want=%h", r.word, e); end
    end
    rx_q.delete();
    drive_sample(8'h5A, 2'd3, 2'b10);
    wait_frames(1);
    if (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r.word !== e) begin failures++; $display("FAIL post_idle_word got=%h want=%h", r.word, e); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    rx_t r;
    logic [15:0] e;
    clear_all();
    drive_sample(8'hC3, 2'd1, 2'b11);
    n = 0; while (m_falls < 7 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (m_falls < 7) begin failures++; $display("FAIL midrst_reach_bit7 got=%0d falls want=7", m_falls); end
    #2 rst = 1'b1;
    #1;
    checks++; if (dac_sclk !== 1'b1)   begin failures++; $display("FAIL midrst_sclk got=%b want=1", dac_sclk); end
    checks++; if (dac_sync_n !== 1'b1) begin failures++; $display("FAIL midrst_sync_n got=%b want=1", dac_sync_n); end
    checks++; if (dac_din !== 1'b0)    begin failures++; $display("FAIL midrst_din got=%b want=0", dac_din); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL midrst_busy got=%b want=0", busy); end
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL midrst_no_resume got=%0d frames want=0", rx_q.size()); end
    drive_sample(8'h96, 2'd2, 2'b01);
    wait_frames(1);
    if (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r.word !== e)   begin failures++; $display("FAIL midrst_after_word got=%h want=%h", r.word, e); end
      checks++; if (r.falls !== 16) begin failures++; $display("FAIL midrst_after_falls got=%0d want=16", r.falls); end
    end
  endtask

  task automatic test_fast_cfg();
    int n;
    logic [15:0] got, e;
    acc5_q.delete(); rx5_q.delete(); exp5_q.delete();
    @(posedge clk); #1;
    v5 = 1'b1; d5 = 8'h3C; c5 = 1'b0; p5 = 2'b11;
    exp5_q.push_back(exp_frame5(8'h3C, 1'b0, 2'b11));
    n = 0; while (!r5 && n < 1000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    d5 = 8'hC3; p5 = 2'b01;
    exp5_q.push_back(exp_frame5(8'hC3, 1'b0, 2'b01));
    n = 0; while (!r5 && n < 1000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    v5 = 1'b0;
    n = 0; while (rx5_q.size() < 2 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (rx5_q.size() !== 2) begin failures++; $display("FAIL fast_frame_count got=%0d want=2", rx5_q.size()); end
    for (int i = 0; i < 2; i++) begin
      if (rx5_q.size() > 0 && exp5_q.size() > 0) begin
        got = rx5_q.pop_front(); e = exp5_q.pop_front();
        checks++; if (got !== e) begin failures++; $display("FAIL fast_word%0d got=%h want=%h", i, got, e); end
      end
    end
    checks++;
    if (acc5_q.size() !== 2 || acc5_q[1] - acc5_q[0] !== 35) begin
      failures++; $display("FAIL fast_accept_spacing got=%0d accepts want=2 spaced 35", acc5_q.size());
    end
  endtask

  task automatic test_random();
    int n;
    rx_t r;
    logic [15:0] e;
    clear_all();
    for (int i = 0; i < 1000; i++) begin
      drive_sample(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    n = 0; while (rx_q.size() < exp_q.size() && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (rx_q.size() !== exp_q.size()) begin failures++; $display("FAIL random_frame_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < 1000; i++) begin
      if (rx_q.size() > 0 && exp_q.size() > 0) begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        checks++; if (r.word !== e) begin failures++; $display("FAIL random_word%0d got=%h want=%h", i, r.word, e); end
      end
    end
  endtask

  initial begin
    #1_500_000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_fast_cfg();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
